// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: queues host read/write requests in a small FIFO and issues
// them one at a time to a single-port synchronous memory.
//
// Ports:
//   clk, reset        - single rising-edge clock; synchronous active-low reset
//   req_valid/ready   - host request handshake (ready = FIFO not full)
//   req_write/addr/wdata - request payload (wdata ignored for reads)
//   mem_wr_en/rd_en   - one-cycle memory strobes, never high together
//   mem_addr/wdata    - registered memory address/data, held between strobes
//   mem_rdata         - memory read data, valid the cycle after mem_rd_en
//   rsp_valid/ready   - read response handshake, rsp_data held until accepted
//   fifo_count        - current FIFO occupancy
//   busy              - FSM not idle or FIFO non-empty
module mem_req_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     mem_wr_en,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RD_WAIT,
    RESP
  } state_t;

  state_t state, next_state;

  logic                  fifo_write [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data  [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;

  logic full, empty, push, pop;
  logic head_write;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full       = (fifo_count == CNT_W'(DEPTH));
  assign empty      = (fifo_count == '0);
  assign req_ready  = !full;
  // Ready depends only on occupancy, so a pop on a full edge never makes
  // room for a push on that same edge.
  assign push       = req_valid && !full;
  assign pop        = (state == IDLE) && !empty;
  assign head_write = fifo_write[rd_ptr];
  assign busy       = (state != IDLE) || !empty;

  // Request FIFO
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_write[wr_ptr] <= req_write;
        fifo_addr[wr_ptr]  <= req_addr;
        fifo_data[wr_ptr]  <= req_wdata;
        wr_ptr             <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state and strobes
  always_comb begin
    next_state = state;
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          next_state = head_write ? WRITE : READ;
        end
      end
      WRITE: begin
        mem_wr_en  = 1'b1;
        next_state = IDLE;
      end
      READ: begin
        mem_rd_en  = 1'b1;
        next_state = RD_WAIT;
      end
      RD_WAIT: begin
        next_state = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Memory-side address/data and read response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (pop) begin
        mem_addr <= fifo_addr[rd_ptr];
        if (head_write) begin
          mem_wdata <= fifo_data[rd_ptr];
        end
      end
      if (state == RD_WAIT) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem_rdata;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed scenarios plus random
// traffic against a queue-based reference model and reference memory.
module tb_mem_req_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [CW-1:0] fifo_count;
  logic          busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  always #5 clk = ~clk;

  mem_req_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .fifo_count(fifo_count), .busy(busy)
  );

  function automatic logic [DW-1:0] init_val(input int unsigned a);
    return DW'(a * 37 + 11);
  endfunction

  // Synchronous memory attached to the controller; rdata is garbage
  // except the cycle after a read strobe.
  logic [DW-1:0] mem [16];
  bit            mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_rd_en ? mem[mem_addr] : DW'($urandom);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_idle();
    rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'hF;
    req_wdata = 8'hFF;
    tick();
    tick();
    checks++;
    if ({fifo_count, req_ready, mem_wr_en, mem_rd_en, busy} !== {CW'(0), 4'b1000}) begin
      errors++;
      $display("FAIL reset_ctrl: count=%0d ready=%b wr=%b rd=%b busy=%b want 0 1 0 0 0",
               fifo_count, req_ready, mem_wr_en, mem_rd_en, busy);
    end
    checks++;
    if ({mem_addr, mem_wdata, rsp_valid, rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rsp_valid=%b rsp_data=%h want all 0",
               mem_addr, mem_wdata, rsp_valid, rsp_data);
    end
    reset = 1'b1;
    set_idle();
    tick();
    checks++;
    if (fifo_count !== '0 || busy !== 1'b0 || mem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_push: count=%0d busy=%b wr=%b want 0 0 0", fifo_count, busy, mem_wr_en);
    end
  endtask

  task automatic test_single_write();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'd3;
    req_wdata = 8'hA5;
    tick();
    set_idle();
    checks++;
    if (fifo_count !== CW'(1) || mem_wr_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_accept: count=%0d wr=%b busy=%b want 1 0 1", fifo_count, mem_wr_en, busy);
    end
    tick();
    checks++;
    if ({mem_wr_en, mem_rd_en, mem_addr, mem_wdata} !== {2'b10, 4'd3, 8'hA5}) begin
      errors++;
      $display("FAIL write_strobe: wr=%b rd=%b addr=%h data=%h want 1 0 3 a5",
               mem_wr_en, mem_rd_en, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if (mem_wr_en !== 1'b0 || busy !== 1'b0 || mem_addr !== 4'd3 || mem_wdata !== 8'hA5) begin
      errors++;
      $display("FAIL write_done: wr=%b busy=%b addr=%h data=%h want 0 0 3 a5",
               mem_wr_en, busy, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_write_read();
    int wr_i, rd_i, rs_i, rs_n;
    logic [DW-1:0] rs_d;
    wr_i = -1; rd_i = -1; rs_i = -1; rs_n = 0; rs_d = '0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'd5;
    req_wdata = 8'h3C;
    tick();
    req_write = 1'b0;
    tick();
    set_idle();
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (mem_wr_en && wr_i < 0) wr_i = i;
      if (mem_rd_en && rd_i < 0) rd_i = i;
      if (rsp_valid) begin
        rs_n++;
        if (rs_i < 0) begin
          rs_i = i;
          rs_d = rsp_data;
        end
      end
      tick();
    end
    checks++;
    if (wr_i != 0 || rd_i - wr_i != 2) begin
      errors++;
      $display("FAIL wr_rd_spacing: wr_at=%0d rd_at=%0d want 0 2", wr_i, rd_i);
    end
    checks++;
    if (rs_n != 1 || rs_d !== 8'h3C || rs_i - rd_i != 2) begin
      errors++;
      $display("FAIL wr_rd_rsp: cycles=%0d data=%h rsp_at=%0d want 1 3c %0d", rs_n, rs_d, rs_i, rd_i + 2);
    end
  endtask

  task automatic test_read_latency();
    int rd_i, rs_i;
    rd_i = -1; rs_i = -1;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd3;
    tick();
    set_idle();
    for (int i = 0; i < 8; i++) begin
      if (mem_rd_en && rd_i < 0) rd_i = i;
      if (rsp_valid && rs_i < 0) begin
        rs_i = i;
        checks++;
        if (rsp_data !== 8'hA5) begin
          errors++;
          $display("FAIL read_data: got %h want a5", rsp_data);
        end
      end
      tick();
    end
    checks++;
    if (rd_i != 1 || rs_i != 3) begin
      errors++;
      $display("FAIL read_latency: rd_at=%0d rsp_at=%0d want 1 3", rd_i, rs_i);
    end
  endtask

  task automatic test_full_stall();
    int pushed, c;
    logic acc;
    pushed = 0;
    c = 0;
    rsp_ready = 1'b0;
    while (pushed < 5 && c < 20) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = AW'(8 + pushed);
      acc = req_ready;
      tick();
      c++;
      if (acc) pushed++;
    end
    req_addr = AW'(13);
    checks++;
    if (c != 5 || fifo_count !== CW'(4) || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_fill: cycles=%0d count=%0d ready=%b want 5 4 0", c, fifo_count, req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (fifo_count !== CW'(4) || req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== init_val(8)) begin
        errors++;
        $display("FAIL full_hold: count=%0d ready=%b rsp_valid=%b data=%h want 4 0 1 %h",
                 fifo_count, req_ready, rsp_valid, rsp_data, init_val(8));
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (fifo_count !== CW'(4) || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_seq0: count=%0d rsp_valid=%b want 4 0", fifo_count, rsp_valid);
    end
    tick();
    checks++;
    if (fifo_count !== CW'(3) || req_ready !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== AW'(9)) begin
      errors++;
      $display("FAIL full_seq1: count=%0d ready=%b rd=%b addr=%h want 3 1 1 9",
               fifo_count, req_ready, mem_rd_en, mem_addr);
    end
    tick();
    set_idle();
    checks++;
    if (fifo_count !== CW'(4)) begin
      errors++;
      $display("FAIL full_seq2: count=%0d want 4", fifo_count);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd2;
    tick();
    req_write = 1'b1;
    req_addr  = 4'd6;
    req_wdata = 8'h11;
    tick();
    checks++;
    if (mem_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_read: rd=%b want 1", mem_rd_en);
    end
    req_addr  = 4'd7;
    req_wdata = 8'h22;
    tick();
    checks++;
    if (fifo_count !== CW'(2) || mem_rd_en !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_rdwait: count=%0d rd=%b rsp_valid=%b busy=%b want 2 0 0 1",
               fifo_count, mem_rd_en, rsp_valid, busy);
    end
    reset = 1'b0;
    set_idle();
    tick();
    checks++;
    if ({fifo_count, rsp_valid, mem_wr_en, mem_rd_en, busy, req_ready} !== {CW'(0), 5'b00001}) begin
      errors++;
      $display("FAIL mid_reset: count=%0d rsp_valid=%b wr=%b rd=%b busy=%b ready=%b want 0 0 0 0 0 1",
               fifo_count, rsp_valid, mem_wr_en, mem_rd_en, busy, req_ready);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | mem_wr_en | mem_rd_en | rsp_valid | busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_release: activity=%b want 0", seen);
    end
  endtask

  task automatic test_random();
    req_t          pend[$];
    logic [DW-1:0] exp_rsp[$];
    logic [DW-1:0] ref_mem [16];
    req_t          h;
    int            sent;
    bit            done;
    sent = 0;
    done = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      tick();
      checks++;
      if (mem_wr_en && mem_rd_en) begin
        errors++;
        $display("FAIL rnd_excl: wr=%b rd=%b want not both", mem_wr_en, mem_rd_en);
      end
      if (mem_wr_en || mem_rd_en) begin
        checks++;
        if (pend.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious_strobe: wr=%b rd=%b with no queued request", mem_wr_en, mem_rd_en);
        end else begin
          h = pend.pop_front();
          if (h.w !== mem_wr_en || h.a !== mem_addr || (h.w && h.d !== mem_wdata)) begin
            errors++;
            $display("FAIL rnd_order: got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h",
                     mem_wr_en, mem_addr, mem_wdata, h.w, h.a, h.d);
          end
          if (h.w) ref_mem[h.a] = h.d;
          else exp_rsp.push_back(ref_mem[h.a]);
        end
      end
      checks++;
      if (fifo_count !== CW'(pend.size())) begin
        errors++;
        $display("FAIL rnd_count: got %0d want %0d", fifo_count, pend.size());
      end
      if (rsp_valid) begin
        checks++;
        if (exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious_rsp: data=%h with no read outstanding", rsp_data);
        end else if (rsp_data !== exp_rsp[0]) begin
          errors++;
          $display("FAIL rnd_rsp_data: got %h want %h", rsp_data, exp_rsp[0]);
        end
      end
      rsp_ready = 1'($urandom_range(0, 1));
      if (rsp_valid && rsp_ready && exp_rsp.size() != 0) void'(exp_rsp.pop_front());
      if (sent < 200) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_write = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
        if (req_valid && req_ready) begin
          pend.push_back('{w: req_write, a: req_addr, d: req_wdata});
          sent++;
        end
      end else begin
        set_idle();
        if (pend.size() == 0 && exp_rsp.size() == 0 && !busy && !rsp_valid) done = 1'b1;
      end
    end
    set_idle();
    checks++;
    if (sent != 200 || pend.size() != 0 || exp_rsp.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain: sent=%0d pending=%0d rsp_pending=%0d want 200 0 0",
               sent, pend.size(), exp_rsp.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    rsp_ready = 1'b0;
    set_idle();
    test_reset();
    test_single_write();
    test_write_read();
    test_read_latency();
    test_full_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
